// File: rtl/alu_pkg.sv
// Opcodes, FSM state type and op classification shared by seq_alu and alu_comb.
// SEQ_ALU_MUL_EN enables the multi-cycle multiply.
package alu_pkg;

    localparam logic [3:0] OP_MOVE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_NOP  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    // True when the op needs the EXEC state (shift by a non-zero amount, or mul).
    function automatic logic is_multi(input logic [3:0] op, input logic shamt_nz);
        logic m;
        m = 1'b0;
        if (op == OP_SLL || op == OP_SRL || op == OP_SRA)
            m = shamt_nz;
`ifdef SEQ_ALU_MUL_EN
        if (op == OP_MUL)
            m = 1'b1;
`endif
        return m;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU ops with carry/overflow flags; shifts here pass operand A through
// (only a zero shift amount reaches this path), mul and illegal opcodes give 0.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_MOVE: result = b;
            OP_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = ~diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_NOT:  result = ~b;
            OP_SLT:  result = WIDTH'($signed(a) < $signed(b));
            OP_SLL, OP_SRL, OP_SRA: result = a;
            default: ;
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Clocked ALU with start/done handshake, bit-serial shifts and optional shift-add
// multiply (enabled by SEQ_ALU_MUL_EN; otherwise opcode 1000 behaves as nop).
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ALUResult,
    output logic [WIDTH-1:0] ResultHi,
    output logic             Zero,
    output logic             Carry,
    output logic             Negative,
    output logic             Overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d, sh_step;
    logic             sh_out;
    logic [SHW-1:0]   shamt;

    logic             out_we;
    logic [WIDTH-1:0] res_d, hi_d;
    logic             c_d, v_d;

    logic [WIDTH-1:0] comb_res;
    logic             comb_c, comb_v;

    assign shamt = in2[SHW-1:0];
    assign busy  = (state_q == S_EXEC);
    assign done  = (state_q == S_DONE);

    alu_comb #(.WIDTH(WIDTH)) u_comb (
        .op       (ALUControl),
        .a        (in1),
        .b        (in2),
        .result   (comb_res),
        .carry    (comb_c),
        .overflow (comb_v)
    );

    always_comb begin
        sh_step = sh_q;
        sh_out  = 1'b0;
        case (op_q)
            OP_SLL: begin sh_step = {sh_q[WIDTH-2:0], 1'b0};         sh_out = sh_q[WIDTH-1]; end
            OP_SRL: begin sh_step = {1'b0, sh_q[WIDTH-1:1]};         sh_out = sh_q[0];       end
            OP_SRA: begin sh_step = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]}; sh_out = sh_q[0];      end
            default: ;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    // acc = {partial high, remaining multiplier bits}; each step adds then shifts right.
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH:0]     mul_sum;

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
`ifdef SEQ_ALU_MUL_EN
        acc_d   = acc_q;
        mcand_d = mcand_q;
`endif
        out_we  = 1'b0;
        res_d   = comb_res;
        hi_d    = '0;
        c_d     = comb_c;
        v_d     = comb_v;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    op_d = ALUControl;
                    if (is_multi(ALUControl, |shamt)) begin
                        state_d = S_EXEC;
                        sh_d    = in1;
                        cnt_d   = CW'(shamt);
`ifdef SEQ_ALU_MUL_EN
                        acc_d   = {{WIDTH{1'b0}}, in1};
                        mcand_d = in2;
                        if (ALUControl == OP_MUL)
                            cnt_d = CW'(WIDTH);
`endif
                    end else begin
                        out_we  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CW'(1);
`ifdef SEQ_ALU_MUL_EN
                if (op_q == OP_MUL) begin
                    acc_d = acc_step;
                    res_d = acc_step[WIDTH-1:0];
                    hi_d  = acc_step[2*WIDTH-1:WIDTH];
                    c_d   = |acc_step[2*WIDTH-1:WIDTH];
                    v_d   = 1'b0;
                end else
`endif
                begin
                    sh_d  = sh_step;
                    res_d = sh_step;
                    c_d   = sh_out;
                    v_d   = 1'b0;
                end
                if (cnt_q == CW'(1)) begin
                    out_we  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            cnt_q     <= '0;
            sh_q      <= '0;
`ifdef SEQ_ALU_MUL_EN
            acc_q     <= '0;
            mcand_q   <= '0;
`endif
            ALUResult <= '0;
            ResultHi  <= '0;
            Zero      <= 1'b0;
            Carry     <= 1'b0;
            Negative  <= 1'b0;
            Overflow  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
`ifdef SEQ_ALU_MUL_EN
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
`endif
            if (out_we) begin
                ALUResult <= res_d;
                ResultHi  <= hi_d;
                Zero      <= (res_d == '0);
                Carry     <= c_d;
                Negative  <= res_d[WIDTH-1];
                Overflow  <= v_d;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=16): directed table, handshake/reset sequences,
// and random ops against an arithmetic reference model.
module tb_seq_alu;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ALUControl = '0;
    logic [W-1:0] in1 = '0;
    logic [W-1:0] in2 = '0;
    logic         busy, done;
    logic [W-1:0] ALUResult, ResultHi;
    logic         Zero, Carry, Negative, Overflow;

    int checks = 0;
    int errors = 0;
    int lat;
    bit seen;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ALUControl (ALUControl),
        .in1        (in1),
        .in2        (in2),
        .busy       (busy),
        .done       (done),
        .ALUResult  (ALUResult),
        .ResultHi   (ResultHi),
        .Zero       (Zero),
        .Carry      (Carry),
        .Negative   (Negative),
        .Overflow   (Overflow)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [15:0] hi;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the opcode definitions.
    function automatic vec_t model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        vec_t e;
        int sa, sb, s, k;
        logic [31:0] p;
        e.op = op; e.a = a; e.b = b;
        e.res = '0; e.hi = '0; e.c = 1'b0; e.v = 1'b0; e.lat = 1;
        sa = int'($signed(a));
        sb = int'($signed(b));
        k  = int'(b[3:0]);
        p  = '0;
        case (op)
            4'h0: e.res = b;
            4'h1: begin
                s = int'(a) + int'(b);
                e.res = s[15:0];
                e.c = s[16];
                e.v = (sa + sb > 32767) || (sa + sb < -32768);
            end
            4'h2: begin
                e.res = a - b;
                e.c = (a >= b);
                e.v = (sa - sb > 32767) || (sa - sb < -32768);
            end
            4'h3: e.res = a & b;
            4'h4: e.res = a | b;
            4'h5: e.res = ~b;
            4'h7: e.res = (sa < sb) ? 16'd1 : 16'd0;
`ifdef SEQ_ALU_MUL_EN
            4'h8: begin
                p = {16'b0, a} * {16'b0, b};
                e.res = p[15:0];
                e.hi = p[31:16];
                e.c = (e.hi != 0);
                e.lat = 17;
            end
`endif
            4'h9: begin
                e.res = a << k;
                if (k != 0) begin e.c = a[16-k]; e.lat = k + 1; end
            end
            4'hA: begin
                e.res = a >> k;
                if (k != 0) begin e.c = a[k-1]; e.lat = k + 1; end
            end
            4'hB: begin
                e.res = $signed(a) >>> k;
                if (k != 0) begin e.c = a[k-1]; e.lat = k + 1; end
            end
            default: ;
        endcase
        e.z = (e.res == 0);
        e.n = e.res[15];
        return e;
    endfunction

    // Launch one op in the IDLE cycle and count cycles until done (bounded).
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int cycles);
        @(negedge clk);
        start = 1'b1; ALUControl = op; in1 = a; in2 = b;
        @(negedge clk);
        start = 1'b0; ALUControl = 4'($urandom); in1 = 16'($urandom); in2 = 16'($urandom);
        cycles = 1;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic run_vec(input vec_t e, input string tag);
        int l;
        do_op(e.op, e.a, e.b, l);
        check({tag, "_lat"}, 32'(l), 32'(e.lat));
        check({tag, "_res"}, {ResultHi, ALUResult}, {e.hi, e.res});
        check({tag, "_zcnv"}, {28'b0, Zero, Carry, Negative, Overflow}, {28'b0, e.z, e.c, e.n, e.v});
    endtask

    vec_t tbl[15];
    vec_t multi_op;
    vec_t r;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'h1, 16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1};
        tbl[1]  = '{4'h2, 16'h1234, 16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};
        tbl[2]  = '{4'h2, 16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
`ifdef SEQ_ALU_MUL_EN
        tbl[3]  = '{4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 17};
`else
        tbl[3]  = '{4'h8, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
`endif
        tbl[4]  = '{4'hB, 16'h8000, 16'h0013, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 4};
        tbl[5]  = '{4'hB, 16'h8000, 16'h0010, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[6]  = '{4'h3, 16'hF0F0, 16'hFF00, 16'hF000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[7]  = '{4'h4, 16'h00F0, 16'h0F00, 16'h0FF0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'h5, 16'h1234, 16'h00FF, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        tbl[9]  = '{4'h7, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1};
        tbl[10] = '{4'h9, 16'h8001, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 2};
        tbl[11] = '{4'hA, 16'h4000, 16'h000F, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16};
        tbl[12] = '{4'hC, 16'h1234, 16'h5678, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[13] = '{4'h0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1};
        tbl[14] = '{4'h1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1};

`ifdef SEQ_ALU_MUL_EN
        multi_op = '{4'h8, 16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 17};
`else
        multi_op = '{4'h9, 16'h0001, 16'h000F, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16};
`endif

        repeat (2) @(negedge clk);
        check("reset_ctl_flags", {26'b0, busy, done, Zero, Carry, Negative, Overflow}, 32'h0);
        check("reset_results", {ResultHi, ALUResult}, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++)
            run_vec(tbl[i], $sformatf("tbl%0d", i));

        // start pulses in EXEC and in DONE must be ignored
        @(negedge clk);
        start = 1'b1; ALUControl = multi_op.op; in1 = multi_op.a; in2 = multi_op.b;
        @(negedge clk);
        start = 1'b0; lat = 1;
        check("exec_busy", {31'b0, busy}, 32'h1);
        repeat (3) begin @(negedge clk); lat++; end
        start = 1'b1; ALUControl = 4'h1; in1 = 16'h0001; in2 = 16'h0001;
        @(negedge clk);
        start = 1'b0; lat++;
        while (!done && lat < 100) begin @(negedge clk); lat++; end
        check("exec_ignore_lat", 32'(lat), 32'(multi_op.lat));
        check("exec_ignore_res", {ResultHi, ALUResult}, {multi_op.hi, multi_op.res});
        start = 1'b1; ALUControl = 4'h1; in1 = 16'h0002; in2 = 16'h0003;
        @(negedge clk);
        start = 1'b0;
        check("done_ignore_ctl", {30'b0, busy, done}, 32'h0);
        check("done_ignore_hold", {ResultHi, ALUResult}, {multi_op.hi, multi_op.res});

        // back-to-back: each start lands in the IDLE cycle right after DONE
        do_op(4'h1, 16'h0002, 16'h0003, lat);
        check("b2b_first_lat", 32'(lat), 32'd1);
        check("b2b_first_res", {16'b0, ALUResult}, 32'h5);
        do_op(4'h2, 16'h0005, 16'h0003, lat);
        check("b2b_second_lat", 32'(lat), 32'd1);
        check("b2b_second_res", {16'b0, ALUResult}, 32'h2);

        // asynchronous reset in the fifth EXEC cycle
        @(negedge clk);
        start = 1'b1; ALUControl = multi_op.op; in1 = multi_op.a; in2 = multi_op.b;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_ctl_flags", {26'b0, busy, done, Zero, Carry, Negative, Overflow}, 32'h0);
        check("midreset_results", {ResultHi, ALUResult}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        check("midreset_no_done", {31'b0, seen}, 32'h0);
        run_vec(multi_op, "post_reset");

        for (int i = 0; i < 300; i++) begin
            r = model(4'($urandom), 16'($urandom), 16'($urandom));
            run_vec(r, $sformatf("rnd%0d_op%h", i, r.op));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, clocked successor to the datapath's 16-bit combinational ALU.
- Adds registered results, full flags, a start/done handshake, multi-cycle shift-add multiply and one-bit-per-cycle shifts.
- Sits in the EX stage of the multi-cycle MIPS datapath. The controller asserts start and stalls on busy until done.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), width of the shift-amount field taken from in2[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch operation; sampled only in IDLE
- ALUControl  input  4  opcode, captured with start
- in1  input  WIDTH  operand A, captured with start
- in2  input  WIDTH  operand B / shift amount, captured with start
- busy  output  1  high while an operation is in flight (EXEC)
- done  output  1  one-cycle pulse: results valid from this cycle
- ALUResult  output  WIDTH  result (low half for mul)
- ResultHi  output  WIDTH  high half of product; 0 for other ops
- Zero  output  1  ALUResult==0 (all ops)
- Carry  output  1  add carry-out / sub no-borrow / last bit shifted out
- Negative  output  1  ALUResult[WIDTH-1]
- Overflow  output  1  signed overflow for add/sub; 0 otherwise

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - All outputs 0, including busy and done.
  - Internal operand, counter and accumulator registers 0.
- Opcodes:
  - 0000 move (in2)
  - 0001 add
  - 0010 sub (in1-in2)
  - 0011 and
  - 0100 or
  - 0101 not (~in2)
  - 0110 nop (result 0)
  - 0111 slt (signed, result 1/0)
  - 1000 mul (unsigned, 2*WIDTH product)
  - 1001 sll, 1010 srl, 1011 sra (in1 shifted by in2[SHW-1:0])
  - 1100-1111 illegal: behave as nop.
- FSM states: IDLE, EXEC, DONE.
  - IDLE & start & single-cycle op (0000-0111, illegal, or shift with amount 0): compute, register outputs, go to DONE. Latency 1 cycle (done in the cycle after start).
  - IDLE & start & mul: load accumulator {0, in1} and multiplicand in2; count = WIDTH; go to EXEC; busy=1.
  - IDLE & start & shift with amount k>0: load in1; count = k; go to EXEC; busy=1.
  - EXEC:
    - mul: one radix-2 shift-add step per cycle.
    - Shift: one bit position per cycle; Carry tracks the bit just shifted out.
    - Counter decrements each cycle; at count==1, write outputs and go to DONE.
    - Latency: mul = WIDTH+1 cycles start-to-done; shift = k+1 cycles.
  - DONE: done=1 for exactly one cycle; busy=0; go to IDLE.
- Handshake:
  - start is ignored in EXEC and DONE; no queueing.
  - start in IDLE on the cycle after DONE is accepted.
  - Operands are needed only on the start cycle.
- Outputs:
  - Result/flag outputs hold their last value until the next done.
  - They are not cleared on start.
- Flags:
  - Zero on ALUResult only (ResultHi ignored).
  - Carry for add = bit WIDTH of the (WIDTH+1)-bit sum.
  - Carry for sub = 1 when in1>=in2 unsigned.
  - Overflow for add/sub by sign rule.
  - For mul: Carry = (ResultHi != 0), Overflow = 0.
  - Logic/move/not/slt/nop: Carry = 0, Overflow = 0.
- Width rules:
  - Sum/difference computed at WIDTH+1 bits and truncated to WIDTH.
  - Shift amount uses only in2[SHW-1:0]; upper bits ignored.
  - sra replicates the MSB.
- Reset mid-operation aborts immediately to IDLE with all outputs zeroed; no done is produced.

Optional Feature:
- SEQ_ALU_MUL_EN defined: mul opcode 1000 as above; ResultHi driven.
- Not defined:
  - 1000 treated as illegal (nop, 1-cycle, result 0, flags 0).
  - ResultHi tied to 0.
  - Multiplier datapath removed.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams (OP_MOVE ... OP_SRA).
  - FSM state encoding.
  - Single-cycle/multi-cycle classification function.
- Sub-module alu_comb: purely combinational single-cycle ops plus flags, parametrised by WIDTH.
- seq_alu wraps alu_comb with the FSM, shift/multiply datapath and output registers.

Test Plan:
- WIDTH=16, add 0x7FFF+0x0001 -> done 1 cycle after start; ALUResult 0x8000, Overflow 1, Negative 1, Carry 0, Zero 0.
- sub 0x1234-0x1234 -> ALUResult 0x0000, Zero 1, Carry 1, Overflow 0; then sub 0x0001-0x0002 -> 0xFFFF, Carry 0, Negative 1.
- mul 0xFFFF*0xFFFF (macro on) -> busy 16 cycles, done at cycle 17; ResultHi 0xFFFE, ALUResult 0x0001, Carry 1. Macro off: done at cycle 1, result 0.
- sra 0x8000 by in2=0x0013 (amount 3) -> done after 4 cycles, ALUResult 0xF000, Carry 0. Same op with amount 0 -> 1-cycle done, result 0x8000.
- start pulsed during EXEC of a mul with different operands -> ignored; mul result unchanged. Back-to-back start on the cycle after done -> accepted.
- rst_n low at EXEC cycle 5 of mul -> outputs 0 asynchronously, no done pulse; next start after release behaves normally.
